// File: rtl/universal_shift_reg.sv
// Purpose: WIDTH-bit storage/shift register with load, clear, shifts, rotates and serial I/O plus a per-word shift counter.
// Latency: every operation takes effect at the next rising clk edge; sout_l/sout_r follow q combinationally.
// Backpressure: none produced; en=0 stalls all state (q, count) and forces word_done low for that edge.
module universal_shift_reg #(
  parameter int              WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int             CW        = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_l,
  input  logic             sin_r,
  output logic [WIDTH-1:0] q,
  output logic             sout_l,
  output logic             sout_r,
  output logic [CW-1:0]    shift_cnt,
  output logic             word_done
);

  // Operation encoding of the mode input.
  typedef enum logic [2:0] {
    MODE_HOLD  = 3'b000,
    MODE_LOAD  = 3'b001,
    MODE_SHL   = 3'b010,
    MODE_LSR   = 3'b011,
    MODE_ROL   = 3'b100,
    MODE_ROR   = 3'b101,
    MODE_CLEAR = 3'b110,
    MODE_ASR   = 3'b111
  } mode_e;

  logic [WIDTH-1:0] r_q;
  logic [CW-1:0]    r_cnt;
  logic             r_word_done;

  logic [WIDTH-1:0] w_q_nxt;
  logic             w_is_shift;
  logic             w_cnt_clr;
  logic             w_cnt_wrap;
  mode_e            w_mode;

  assign w_mode     = mode_e'(mode);
  // The WIDTH-th shift of a word is the one taken while the count sits at WIDTH-1.
  assign w_cnt_wrap = (r_cnt == CW'(WIDTH - 1));

  // Decode the operation into the next register value and its effect on the counter.
  always_comb begin
    w_q_nxt    = r_q;
    w_is_shift = 1'b0;
    w_cnt_clr  = 1'b0;
    case (w_mode)
      MODE_HOLD: begin
        w_q_nxt = r_q;
      end
      MODE_LOAD: begin
        w_q_nxt   = d;
        w_cnt_clr = 1'b1;
      end
      MODE_SHL: begin
        w_q_nxt    = {r_q[WIDTH-2:0], sin_l};
        w_is_shift = 1'b1;
      end
      MODE_LSR: begin
        w_q_nxt    = {sin_r, r_q[WIDTH-1:1]};
        w_is_shift = 1'b1;
      end
      MODE_ROL: begin
        w_q_nxt    = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
        w_is_shift = 1'b1;
      end
      MODE_ROR: begin
        w_q_nxt    = {r_q[0], r_q[WIDTH-1:1]};
        w_is_shift = 1'b1;
      end
      MODE_CLEAR: begin
        // Clear goes to zero, deliberately not to RESET_VAL.
        w_q_nxt   = '0;
        w_cnt_clr = 1'b1;
      end
      MODE_ASR: begin
        // Sign bit replicates; sin_r plays no part here.
        w_q_nxt    = {r_q[WIDTH-1], r_q[WIDTH-1:1]};
        w_is_shift = 1'b1;
      end
      default: begin
        w_q_nxt = r_q;
      end
    endcase
  end

  // Register, shift counter and word_done pulse; reset discards any partial word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_q         <= RESET_VAL;
      r_cnt       <= '0;
      r_word_done <= 1'b0;
    end else begin
      r_word_done <= 1'b0;
      if (en) begin
        r_q <= w_q_nxt;
        if (w_cnt_clr) begin
          r_cnt <= '0;
        end else if (w_is_shift) begin
          if (w_cnt_wrap) begin
            r_cnt       <= '0;
            r_word_done <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
      end
    end
  end

  assign q         = r_q;
  assign sout_l    = r_q[WIDTH-1];
  assign sout_r    = r_q[0];
  assign shift_cnt = r_cnt;
  assign word_done = r_word_done;

endmodule

// File: tb/tb_universal_shift_reg.sv
// Purpose: directed-vector scoreboard bench for universal_shift_reg (WIDTH=8, RESET_VAL=A5).
// Latency: each vector's expected state is checked 1 ns after the edge that applies it.
// Backpressure: n/a; the driver issues one vector per cycle, the monitor drains the queue.
module tb_universal_shift_reg;

  logic       clk;
  logic       reset_n;
  logic       en;
  logic [2:0] mode;
  logic [7:0] d;
  logic       sin_l;
  logic       sin_r;
  logic [7:0] q;
  logic       sout_l;
  logic       sout_r;
  logic [3:0] shift_cnt;
  logic       word_done;

  logic       async_strobe;
  int         checks;
  int         errors;

  typedef struct {
    string      name;
    logic [7:0] q;
    logic [3:0] cnt;
    logic       wd;
  } exp_t;

  exp_t sb[$];

  universal_shift_reg #(
    .WIDTH    (8),
    .RESET_VAL(8'hA5)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .en       (en),
    .mode     (mode),
    .d        (d),
    .sin_l    (sin_l),
    .sin_r    (sin_r),
    .q        (q),
    .sout_l   (sout_l),
    .sout_r   (sout_r),
    .shift_cnt(shift_cnt),
    .word_done(word_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: after each rising edge (or an asynchronous-reset strobe) pop one expectation and compare.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk or posedge async_strobe);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (q !== e.q || shift_cnt !== e.cnt || word_done !== e.wd ||
            sout_l !== e.q[7] || sout_r !== e.q[0]) begin
          errors++;
          $display("FAIL %s: got q=%h cnt=%0d wd=%b sout_l=%b sout_r=%b, want q=%h cnt=%0d wd=%b sout_l=%b sout_r=%b",
                   e.name, q, shift_cnt, word_done, sout_l, sout_r,
                   e.q, e.cnt, e.wd, e.q[7], e.q[0]);
        end
      end
    end
  end

  // Apply one vector at the falling edge and queue the state expected after the next rising edge.
  task automatic step(input logic e_in, input logic [2:0] m, input logic [7:0] dd,
                      input logic sl, input logic sr,
                      input logic [7:0] eq, input logic [3:0] ec, input logic ew,
                      input string nm);
    exp_t x;
    @(negedge clk);
    en    = e_in;
    mode  = m;
    d     = dd;
    sin_l = sl;
    sin_r = sr;
    x.name = nm;
    x.q    = eq;
    x.cnt  = ec;
    x.wd   = ew;
    sb.push_back(x);
  endtask

  // Drop reset between edges and check that state has already returned to reset values.
  task automatic async_reset(input string nm);
    exp_t x;
    @(negedge clk);
    #2;
    en      = 1'b0;
    reset_n = 1'b0;
    x.name  = nm;
    x.q     = 8'hA5;
    x.cnt   = 4'd0;
    x.wd    = 1'b0;
    sb.push_back(x);
    async_strobe = 1'b1;
    #1;
    async_strobe = 1'b0;
  endtask

  task automatic release_reset();
    @(negedge clk);
    en      = 1'b0;
    reset_n = 1'b1;
  endtask

  logic [7:0] rol_exp [8];

  initial begin
    checks       = 0;
    errors       = 0;
    async_strobe = 1'b0;
    reset_n      = 1'b0;
    en           = 1'b0;
    mode         = 3'b000;
    d            = 8'h00;
    sin_l        = 1'b0;
    sin_r        = 1'b0;
    rol_exp      = '{8'h03, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h60, 8'hC0, 8'h81};

    async_reset("reset_state");
    release_reset();
    step(1, 3'b000, 8'hFF, 1, 1, 8'hA5, 4'd0, 0, "hold_after_reset1");
    step(1, 3'b000, 8'hFF, 1, 1, 8'hA5, 4'd0, 0, "hold_after_reset2");

    // Load, shift-left, logical shift-right.
    step(1, 3'b001, 8'h3C, 0, 0, 8'h3C, 4'd0, 0, "load_3C");
    step(1, 3'b010, 8'h00, 1, 0, 8'h79, 4'd1, 0, "shl_sin1");
    step(1, 3'b011, 8'h00, 1, 0, 8'h3C, 4'd2, 0, "lsr_sin0");
    step(1, 3'b000, 8'h00, 1, 1, 8'h3C, 4'd2, 0, "hold_keeps_cnt");

    // Eight rotate-lefts wrap the counter and pulse word_done once.
    step(1, 3'b001, 8'h81, 0, 0, 8'h81, 4'd0, 0, "load_81");
    for (int i = 0; i < 8; i++)
      step(1, 3'b100, 8'h00, 0, 0, rol_exp[i], (i == 7) ? 4'd0 : 4'(i + 1), (i == 7),
           $sformatf("rol_%0d", i + 1));
    step(1, 3'b100, 8'h00, 0, 0, 8'h03, 4'd1, 0, "rol_9");
    step(1, 3'b000, 8'h00, 0, 0, 8'h03, 4'd1, 0, "hold_after_rol");

    // Arithmetic shift, stall with en=0, synchronous clear to zero.
    step(1, 3'b001, 8'h80, 0, 0, 8'h80, 4'd0, 0, "load_80");
    step(1, 3'b111, 8'h00, 0, 0, 8'hC0, 4'd1, 0, "asr_neg");
    for (int i = 0; i < 3; i++)
      step(0, 3'b010, 8'hFF, 1, 1, 8'hC0, 4'd1, 0, $sformatf("en0_hold_%0d", i));
    step(1, 3'b110, 8'hFF, 1, 1, 8'h00, 4'd0, 0, "sync_clear");

    // Remaining shift flavours.
    step(1, 3'b011, 8'h00, 0, 1, 8'h80, 4'd1, 0, "lsr_sin1");
    step(1, 3'b101, 8'h00, 1, 1, 8'h40, 4'd2, 0, "ror_1");
    step(1, 3'b101, 8'h00, 1, 1, 8'h20, 4'd3, 0, "ror_2");
    step(1, 3'b001, 8'h01, 0, 0, 8'h01, 4'd0, 0, "load_01");
    step(1, 3'b101, 8'h00, 0, 0, 8'h80, 4'd1, 0, "ror_wrap_bit");
    step(1, 3'b111, 8'h00, 0, 0, 8'hC0, 4'd2, 0, "asr_neg2");
    step(1, 3'b001, 8'h40, 0, 0, 8'h40, 4'd0, 0, "load_40");
    step(1, 3'b111, 8'h00, 0, 1, 8'h20, 4'd1, 0, "asr_ignores_sin_r");
    step(1, 3'b010, 8'h00, 0, 1, 8'h40, 4'd2, 0, "shl_sin0");
    step(1, 3'b100, 8'h00, 0, 0, 8'h80, 4'd3, 0, "rol_1");
    step(1, 3'b100, 8'h00, 0, 0, 8'h01, 4'd4, 0, "rol_msb_wrap");

    // Load on the 7th shift count: counter restarts, no pulse.
    step(1, 3'b001, 8'h00, 0, 0, 8'h00, 4'd0, 0, "load_00");
    step(1, 3'b010, 8'h00, 1, 0, 8'h01, 4'd1, 0, "fill_1");
    step(1, 3'b010, 8'h00, 1, 0, 8'h03, 4'd2, 0, "fill_2");
    step(1, 3'b010, 8'h00, 1, 0, 8'h07, 4'd3, 0, "fill_3");
    step(1, 3'b010, 8'h00, 1, 0, 8'h0F, 4'd4, 0, "fill_4");
    step(1, 3'b010, 8'h00, 1, 0, 8'h1F, 4'd5, 0, "fill_5");
    step(1, 3'b010, 8'h00, 1, 0, 8'h3F, 4'd6, 0, "fill_6");
    step(1, 3'b010, 8'h00, 1, 0, 8'h7F, 4'd7, 0, "fill_7");
    step(1, 3'b001, 8'h55, 0, 0, 8'h55, 4'd0, 0, "load_midword");
    step(1, 3'b010, 8'h00, 0, 0, 8'hAA, 4'd1, 0, "shl_after_load");

    // Serializer with a 2-cycle gap; sout_l before each shift is 1,0,1,1,0,1,0,0.
    step(1, 3'b001, 8'hB4, 0, 0, 8'hB4, 4'd0, 0, "ser_load_B4");
    step(1, 3'b010, 8'h00, 0, 0, 8'h68, 4'd1, 0, "ser_1");
    step(1, 3'b010, 8'h00, 0, 0, 8'hD0, 4'd2, 0, "ser_2");
    step(1, 3'b010, 8'h00, 0, 0, 8'hA0, 4'd3, 0, "ser_3");
    step(1, 3'b010, 8'h00, 0, 0, 8'h40, 4'd4, 0, "ser_4");
    step(0, 3'b010, 8'h00, 1, 1, 8'h40, 4'd4, 0, "ser_idle_1");
    step(0, 3'b010, 8'h00, 1, 1, 8'h40, 4'd4, 0, "ser_idle_2");
    step(1, 3'b010, 8'h00, 0, 0, 8'h80, 4'd5, 0, "ser_5");
    step(1, 3'b010, 8'h00, 0, 0, 8'h00, 4'd6, 0, "ser_6");
    step(1, 3'b010, 8'h00, 0, 0, 8'h00, 4'd7, 0, "ser_7");
    step(1, 3'b010, 8'h00, 0, 0, 8'h00, 4'd0, 1, "ser_8_done");
    step(0, 3'b010, 8'h00, 0, 0, 8'h00, 4'd0, 0, "done_clears_en0");

    // Reset mid-word discards the partial count.
    step(1, 3'b001, 8'h0F, 0, 0, 8'h0F, 4'd0, 0, "load_0F");
    step(1, 3'b010, 8'h00, 1, 0, 8'h1F, 4'd1, 0, "pre_rst_1");
    step(1, 3'b010, 8'h00, 1, 0, 8'h3F, 4'd2, 0, "pre_rst_2");
    step(1, 3'b010, 8'h00, 1, 0, 8'h7F, 4'd3, 0, "pre_rst_3");
    async_reset("reset_midword");
    release_reset();
    step(1, 3'b010, 8'h00, 0, 0, 8'h4A, 4'd1, 0, "shl_after_reset");
    step(1, 3'b000, 8'h00, 0, 0, 8'h4A, 4'd1, 0, "final_hold");

    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expectations left, want 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
